// File: rtl/fpmul_pkg.sv
// Shared constants and the {valid,id} tag carried beside the multiplier
// datapath of the fpmul arbiter.
package fpmul_pkg;

    localparam int FP_W    = 32;
    localparam int ID_W    = 3;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpmul_arbiter_rr.sv
// Round-robin grant: search starts one past the last accepted requester.
// Grants only while en is high; the pointer advances on every grant.
module rr_arbiter
    import fpmul_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0]   NR   = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    logic [IW-1:0] nxt;
    logic [IW-1:0] idx;
    logic [IW:0]   sum;
    logic          hit;

    always_comb begin
        gnt = '0;
        idx = '0;
        sum = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, nxt} + k[IW:0];
            if (sum >= NR)
                sum = sum - NR;
            if (!hit && en && req[sum[IW-1:0]]) begin
                hit = 1'b1;
                idx = sum[IW-1:0];
            end
        end
        if (hit)
            gnt[idx] = 1'b1;
    end

    assign gnt_id = ID_W'(idx);

    always_ff @(posedge clk) begin
        if (!rst)
            nxt <= '0;
        else if (hit)
            nxt <= (idx == LAST) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one fixed-latency FP multiplier among NUM_REQ requesters with an
// in-order result FIFO. Define FPMUL_ARB_PERF_EN for issue/stall counters.
module fpmul_arbiter
    import fpmul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic [FP_W-1:0]         mul_a,
    output logic [FP_W-1:0]         mul_b,
    input  logic [FP_W-1:0]         mul_z,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [FP_W-1:0]         rsp_z,
    output logic [ID_W-1:0]         rsp_id
`ifdef FPMUL_ARB_PERF_EN
    ,
    output logic [31:0]             perf_issue,
    output logic [31:0]             perf_stall
`endif
);

    localparam int DEPTH = MUL_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DC    = CW'(DEPTH);
    localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               accept;
    logic               credit;
    logic               push;
    logic               pop;
    logic [CW-1:0]      occ;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      wp;
    logic [PW-1:0]      rp;
    logic [FP_W-1:0]    sel_a;
    logic [FP_W-1:0]    sel_b;
    tag_t               iss_tag;
    tag_t               sr [MUL_LAT];
    logic [FP_W-1:0]    mem_z [DEPTH];
    logic [ID_W-1:0]    mem_id [DEPTH];

    // occ counts pipeline plus FIFO; a pop this cycle frees a slot now
    assign pop    = rsp_valid & rsp_ready;
    assign credit = rst & ((occ < DC) | pop);

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (credit),
        .req   (req_valid),
        .gnt   (gnt),
        .gnt_id(gnt_id)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[FP_W*i +: FP_W];
                sel_b = req_b[FP_W*i +: FP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_a   <= '0;
            mul_b   <= '0;
            iss_tag <= '0;
            for (int i = 0; i < MUL_LAT; i++)
                sr[i] <= '0;
        end else begin
            mul_a   <= sel_a;
            mul_b   <= sel_b;
            iss_tag <= '{valid: accept, id: gnt_id};
            sr[0]   <= iss_tag;
            for (int i = 1; i < MUL_LAT; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign push = sr[MUL_LAT-1].valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_z[wp]  <= mul_z;
            mem_id[wp] <= sr[MUL_LAT-1].id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            occ <= '0;
        end else begin
            if (push)
                wp <= (wp == PLAST) ? '0 : wp + 1'b1;
            if (pop)
                rp <= (rp == PLAST) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            occ <= occ + CW'(accept) - CW'(pop);
        end
    end

    assign rsp_valid = (cnt != '0);
    assign rsp_z     = rsp_valid ? mem_z[rp]  : '0;
    assign rsp_id    = rsp_valid ? mem_id[rp] : '0;

`ifdef FPMUL_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && perf_issue != '1)
                perf_issue <= perf_issue + 1'b1;
            if (|req_valid && !accept && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: vector table, scoreboard of
// expected {id, z}, and sequences for backpressure and mid-run reset.
module tb_fpmul_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_z;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_z;
    logic [2:0]      rsp_id;
`ifdef FPMUL_ARB_PERF_EN
    logic [31:0]     perf_issue;
    logic [31:0]     perf_stall;
`endif

    fpmul_arbiter #(
        .NUM_REQ(N),
        .MUL_LAT(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_z    (mul_z),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_z    (rsp_z),
        .rsp_id   (rsp_id)
`ifdef FPMUL_ARB_PERF_EN
        ,
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // truncating multiply for normal operands; zero exponent gives zero
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return 32'd0;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    logic [31:0] zp [LAT];
    always @(posedge clk) begin
        zp[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < LAT; i++)
            zp[i] <= zp[i-1];
    end
    assign mul_z = zp[LAT-1];

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] z;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;

    exp_t        sb[$];
    int          acc_log[$];
    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    int          n_rsp  = 0;
    bit          mon_en = 1'b0;
    bit          held   = 1'b0;
    logic [31:0] hz;
    logic [2:0]  hid;
    logic [N-1:0] acc_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            held = 1'b0;
        end else begin
            chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{id: 3'(i),
                                   z: fmul(req_a[32*i +: 32], req_b[32*i +: 32])});
                    acc_log.push_back(i);
                    n_acc++;
                end
            end
            if (held) begin
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_z", rsp_z, hz);
                chk("stall_id", 32'(rsp_id), 32'(hid));
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(rsp_id), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_z", rsp_z, e.z);
                end
            end
            held = rsp_valid && !rsp_ready;
            hz   = rsp_z;
            hid  = rsp_id;
        end
    end

    task automatic do_reset();
        mon_en    = 1'b0;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        acc_log.delete();
        mon_en = 1'b1;
    endtask

    // mode 0: rsp_ready low, 1: high, 2: toggling
    task automatic run(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            acc_m = req_valid & req_ready;
            @(posedge clk);
            #1;
            rsp_ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : k[0];
            for (int i = 0; i < N; i++) begin
                if (acc_m[i]) begin
                    req_a[32*i +: 32] = rnd_fp();
                    req_b[32*i +: 32] = rnd_fp();
                end
            end
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0)
                break;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[4];
        int   a0;
        int   r0;
        int   lat;

        vt[0] = '{2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
        vt[1] = '{0, 32'h3F80_0000, 32'h4120_0000, 32'h4120_0000};
        vt[2] = '{1, 32'hC000_0000, 32'h4080_0000, 32'hC100_0000};
        vt[3] = '{3, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};

        rst       = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'h3F80_0000;
            req_b[32*i +: 32] = 32'h3F80_0000;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_z", rsp_z, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        do_reset();

        for (int v = 0; v < 4; v++) begin
            req_a[32*vt[v].id +: 32] = vt[v].a;
            req_b[32*vt[v].id +: 32] = vt[v].b;
            req_valid = N'(1) << vt[v].id;
            @(negedge clk);
            chk($sformatf("vec%0d_grant", v), 32'(req_ready), 32'(N'(1) << vt[v].id));
            @(posedge clk);
            #1;
            req_valid = '0;
            lat = 0;
            while (lat < 20) begin
                @(negedge clk);
                lat++;
                if (rsp_valid)
                    break;
            end
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(LAT + 2));
            chk($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vt[v].id));
            chk($sformatf("vec%0d_z", v), rsp_z, vt[v].z);
            @(posedge clk);
            #1;
        end
        drain();

        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = rnd_fp();
            req_b[32*i +: 32] = rnd_fp();
        end
        do_reset();
        req_valid = '1;
        a0 = n_acc;
        r0 = n_rsp;
        run(24, 1);
        chk("stream_accepts", 32'(n_acc - a0), 32'd24);
        chk("stream_results", 32'(n_rsp - r0), 32'd20);
        chk("grant_log_size", 32'(acc_log.size() >= 16), 32'd1);
        for (int k = 0; k < 16 && k < acc_log.size(); k++)
            chk($sformatf("grant_%0d", k), 32'(acc_log[k]), 32'(k % N));
        drain();

        req_valid = '1;
        rsp_ready = 1'b0;
        a0 = n_acc;
        run(10, 0);
        @(negedge clk);
        chk("full_accepts", 32'(n_acc - a0), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        a0 = n_acc;
        r0 = n_rsp;
        run(12, 1);
        chk("resume_drained", 32'(n_rsp - r0 >= 4), 32'd1);
        chk("resume_issue", 32'(n_acc - a0 > 0), 32'd1);

        run(40, 2);
        drain();

        req_valid = '1;
        rsp_ready = 1'b0;
        run(5, 0);
        @(negedge clk);
        chk("pre_rst_queued", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_z", rsp_z, 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_mul_a", mul_a, 32'd0);
        chk("mid_rst_mul_b", mul_b, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        sb.delete();
        acc_log.delete();
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        run(8, 1);
        drain();

`ifdef FPMUL_ARB_PERF_EN
        begin
            int c;
            int cyc;
            do_reset();
            rsp_ready = 1'b0;
            req_valid = N'(1);
            c   = 0;
            cyc = 0;
            while (cyc < 60) begin
                @(negedge clk);
                if (req_valid[0] && req_ready[0])
                    c++;
                cyc++;
                @(posedge clk);
                #1;
                if (cyc == 7)
                    rsp_ready = 1'b1;
                if (c == 10) begin
                    req_valid = '0;
                    break;
                end
            end
            @(negedge clk);
            chk("perf_issue", perf_issue, 32'd10);
            chk("perf_stall", perf_stall, 32'd3);
            drain();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
